mux4_bus_arbiter: RTL and testbench
===================================

Name: mux4_bus_arbiter

Overview:
- Round-robin arbiter that shares the 32-bit 4:1 datapath mux between four requesters.
- Owns the mux select `s[1:0]`: requester `i` is wired to mux input `Ii`. The arbiter grants one requester at a time and drives `sel` to match.
- Sits between the microprogram controller's bus-request sources and the operand/bus mux.
- Guarantees fairness through a rotating priority pointer and a bounded hold time.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles a grant is held before forced release. Legal range 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  4  request per requester; bit `i` selects mux input `Ii`.
- done  input  4  release strobe per requester; sampled only for the current owner.
- gnt  output  4  one-hot grant, or 0 when idle; registered.
- sel  output  2  mux select, wired to mux `s`; registered.
- busy  output  1  high while any grant is active; equals `|gnt`.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - gnt=4'b0000, sel=2'd0, busy=0, timeout=0.
  - Priority pointer ptr=2'd0, hold counter=0, state=IDLE.
- State IDLE:
  - If req==0: stay in IDLE; gnt=0; sel holds its last value so the mux output stays stable.
  - If req!=0: pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). On the next edge, gnt=onehot(winner), sel=winner, counter=1, state=GRANT.
  - Latency from req to gnt is exactly 1 cycle.
- State GRANT (owner o=sel). A release condition is any of:
  - done[o]==1
  - req[o]==0
  - counter==MAX_HOLD
- On release:
  - ptr <= o+1 (mod 4).
  - Re-arbitrate in the same cycle over req with owner bit o masked, scanning from o+1.
  - Another requester pending: next edge grants it directly, with no idle bubble.
  - No other requester but req[o] still high and release was by done or timeout: re-grant o, counter=1.
  - Nothing pending: gnt=0, state=IDLE, sel holds o.
- No release: counter increments; gnt and sel are unchanged.
- timeout pulses for exactly the cycle after a counter==MAX_HOLD release, and only if done[o] and !req[o] were both false in the release cycle. done takes precedence over timeout when they coincide.
- done and req bits of non-owners are ignored; done on a non-owner has no effect.
- gnt is always one-hot or zero; sel always equals the index of the set gnt bit while busy.
- Counter saturates at MAX_HOLD and never wraps.
- Reset mid-grant: the grant drops asynchronously, ptr returns to 0, and any in-flight transfer is abandoned.

Optional Feature:
- Macro: MUX4_ARB_LOCK_EN.
- Defined:
  - Adds input port `lock` (1 bit).
  - While state=GRANT and lock==1, the counter is frozen and the MAX_HOLD release is suppressed. done[o] and req[o] deassertion still release.
  - timeout never pulses while lock is high.
  - lock is ignored in IDLE.
- Undefined: no `lock` port; MAX_HOLD release is always active.

Test Plan:
- Reset then req=4'b0100 → 1 cycle later gnt=4'b0100, sel=2, busy=1. Deassert req → next cycle gnt=0, sel stays 2.
- req=4'b1111 held, done pulsed on the owner every 2nd cycle → grant order 0,1,2,3,0 with no idle cycle between grants.
- MAX_HOLD=8, req=4'b0011 held, no done → owner 0 holds 8 cycles, timeout pulses once, gnt moves to 4'b0010.
- Only req[3] high, no done, MAX_HOLD=8 → timeout every 8 cycles, immediate re-grant of 3, busy stays 1.
- Assert rst mid-grant with gnt=4'b1000 → gnt=0 and sel=0 asynchronously. After release with req=4'b1010 → gnt=4'b0010, since ptr was reset to 0.
- With MUX4_ARB_LOCK_EN: lock=1, req=4'b0011, owner 0 → holds 20 cycles with no timeout. Drop lock → release at MAX_HOLD, grant moves to 1.

Source files
------------

// File: rtl/mux4_bus_arbiter_if.sv
// Handshake bundle between the four bus requesters and the mux select arbiter.
// master = requester side, slave = arbiter side.
interface mux4_bus_arbiter_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  modport master (output req, done, input gnt, sel, busy, timeout);
  modport slave  (input req, done, output gnt, sel, busy, timeout);
endinterface

// File: rtl/mux4_bus_arbiter.sv
// Round-robin arbiter owning the 4:1 datapath mux select, with a bounded hold time.
// Define MUX4_ARB_LOCK_EN to add a lock input that suspends the MAX_HOLD release.
module mux4_bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef MUX4_ARB_LOCK_EN
  input  logic lock,
`endif
  mux4_bus_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t           st;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       gnt_q;
  logic [1:0]       sel_q;
  logic             to_q;

  logic [3:0] own;
  logic [3:0] cand;
  logic [1:0] start;
  logic [1:0] win;
  logic       found;
  logic       lk;
  logic       hold_max;
  logic       rel;

  // First set bit of v scanning s, s+1, s+2, s+3 (mod 4); MSB flags a hit.
  function automatic logic [2:0] pick(input logic [3:0] v, input logic [1:0] s);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = s + 2'(k);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_own
    assign own[i] = (sel_q == 2'(i));
  end

  always_comb begin
`ifdef MUX4_ARB_LOCK_EN
    lk = lock;
`else
    lk = 1'b0;
`endif
    hold_max = (cnt == CNT_W'(MAX_HOLD)) && !lk;
    rel      = (st == GRANT) && (|(bus.done & own) || !(|(bus.req & own)) || hold_max);
    // While granted, the owner is masked so a release hands off to someone else first.
    if (st == GRANT) begin
      cand  = bus.req & ~own;
      start = sel_q + 2'd1;
    end else begin
      cand  = bus.req;
      start = ptr;
    end
    {found, win} = pick(cand, start);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      gnt_q <= 4'b0000;
      sel_q <= 2'd0;
      to_q  <= 1'b0;
    end else begin
      to_q <= 1'b0;
      case (st)
        IDLE: begin
          if (found) begin
            st    <= GRANT;
            gnt_q <= 4'b0001 << win;
            sel_q <= win;
            cnt   <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (rel) begin
            ptr  <= sel_q + 2'd1;
            to_q <= hold_max && !(|(bus.done & own)) && (|(bus.req & own));
            if (found) begin
              gnt_q <= 4'b0001 << win;
              sel_q <= win;
              cnt   <= CNT_W'(1);
            end else if (|(bus.req & own)) begin
              cnt <= CNT_W'(1);
            end else begin
              // sel keeps the last owner so the mux output stays stable while idle.
              st    <= IDLE;
              gnt_q <= 4'b0000;
              cnt   <= '0;
            end
          end else if (!lk && cnt < CNT_W'(MAX_HOLD)) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = |gnt_q;
  assign bus.timeout = to_q;
endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// Bench for mux4_bus_arbiter: vector table plus hand-written reset, done/timeout and lock sequences.
module tb_mux4_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux4_bus_arbiter_if bif();
`ifdef MUX4_ARB_LOCK_EN
  logic lock = 1'b0;
`endif

  mux4_bus_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
`ifdef MUX4_ARB_LOCK_EN
    .lock(lock),
`endif
    .bus (bif.slave)
  );

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] done;
    logic       lk;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       to;
  } vec_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       to;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                     input logic [1:0] s, input logic t);
    vec_t v;
    v.req = r; v.done = d; v.lk = 1'b0; v.gnt = g; v.sel = s; v.to = t;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input exp_t e);
    checks++;
    if (bif.gnt !== e.gnt || bif.sel !== e.sel || bif.busy !== (|e.gnt) || bif.timeout !== e.to) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
               name, bif.gnt, bif.sel, bif.busy, bif.timeout, e.gnt, e.sel, |e.gnt, e.to);
    end
  endtask

  // Drive one cycle at the falling edge, queue the expected post-edge outputs, compare after the edge.
  task automatic cyc(input string name, input logic [3:0] r, input logic [3:0] d, input logic l,
                     input logic [3:0] g, input logic [1:0] s, input logic t);
    exp_t e;
    bif.req  = r;
    bif.done = d;
`ifdef MUX4_ARB_LOCK_EN
    lock = l;
`else
    if (l) $display("note: lock requested in a build without lock");
`endif
    e.gnt = g; e.sel = s; e.to = t;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, sb.pop_front());
    end
  endtask

  initial begin
    exp_t z;
    z = '0;
    bif.req  = 4'b0000;
    bif.done = 4'b0000;

    // Round robin with done every 2nd cycle: 0,1,2,3,0 back to back, non-owner done ignored.
    add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
    add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
    add(4'b1111, 4'b0001, 4'b0010, 2'd1, 1'b0);
    add(4'b1111, 4'b0101, 4'b0010, 2'd1, 1'b0);
    add(4'b1111, 4'b0010, 4'b0100, 2'd2, 1'b0);
    add(4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0);
    add(4'b1111, 4'b0100, 4'b1000, 2'd3, 1'b0);
    add(4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0);
    add(4'b1111, 4'b1000, 4'b0001, 2'd0, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // Single requester 2, then drop: sel holds 2 while idle.
    add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);
    // req=0011 from ptr=3: owner 0 holds 8 cycles, timeout hands over to 1.
    for (int i = 0; i < 8; i++) add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0);
    add(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1);
    add(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0);
    add(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);
    // Only req[3]: timeout every 8 cycles with immediate re-grant.
    for (int i = 0; i < 8; i++) add(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    add(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1);
    for (int i = 0; i < 7; i++) add(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    add(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1);

    repeat (2) @(negedge clk);
    check("reset_state", z);
    rst = 1'b0;

    for (int k = 0; k < vt.size(); k++)
      cyc($sformatf("vec[%0d]", k), vt[k].req, vt[k].done, vt[k].lk, vt[k].gnt, vt[k].sel, vt[k].to);

    // Reset in the middle of the grant to 3: outputs drop before the next clock edge.
    #2 rst = 1'b1;
    #1 check("async_reset_midgrant", z);
    @(negedge clk);
    rst = 1'b0;
    cyc("post_reset_ptr0", 4'b1010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0);

    // done coinciding with the MAX_HOLD cycle: re-grant without a timeout pulse.
    for (int i = 0; i < 7; i++)
      cyc($sformatf("coinc_hold[%0d]", i), 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0);
    cyc("coinc_done_at_max", 4'b0010, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
    cyc("coinc_cnt_restart", 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0);
    cyc("coinc_release", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);

`ifdef MUX4_ARB_LOCK_EN
    // ptr=2, req=0011 -> owner 0; locked for 20 cycles, then normal MAX_HOLD release.
    for (int i = 0; i < 20; i++)
      cyc($sformatf("lock_hold[%0d]", i), 4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 7; i++)
      cyc($sformatf("unlock_count[%0d]", i), 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc("unlock_timeout", 4'b0011, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
